control_issue_unit: RTL and testbench
=====================================

Name: control_issue_unit

Overview:
- Registered, handshaked successor to the combinational decode-stage control decoder.
- Decodes opcode/func into the control bundle. Holds the bundle in an output register with a valid/ready handshake toward the execute stage.
- Inserts bubbles on hazard and supports flush.
- Adds multi-cycle MULT/DIV tracking that blocks dependent MFHI/MFLO and a second MULT/DIV until the unit is free.

Parameters:
- OPCODE_LENGTH, 6, opcode width.
- FUNCT_LENGTH, 6, func width.
- ALU_OP_WIDTH, 4, alu_op width.
- MULDIV_LAT, 4, busy cycles after a MULT/DIV issue. Legal range is 1 or more.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present at decode.
- in_ready  out  1  instruction consumed this cycle.
- opcode  in  OPCODE_LENGTH  instruction opcode.
- func  in  FUNCT_LENGTH  R-type function field.
- has_hazard  in  1  data hazard; inserts a bubble.
- flush  in  1  branch/jump redirect; kills the held bundle.
- out_valid  out  1  control bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- reg_dst, mem_to_reg, reg_write, mem_read, mem_write, jr, do_extend, is_LB_SB, is_imm, is_src1_valid, is_src2_valid  out  1 each  registered control bits.
- alu_src  out  2  bit0 selects operand a from the shift amount; bit1 selects operand b from the immediate.
- branch  out  3  branch kind.
- jump  out  2  01 = j, 10 = jal.
- alu_op  out  ALU_OP_WIDTH  ALU operation.
- cache_en  out  1  mem_read OR mem_write (combinational from registered bits).
- muldiv_busy  out  1  MULT/DIV in flight.
- illegal_op  out  1  see Optional Feature.

Behaviour:
- Clock and reset: single clock, clk. Reset rst_b is asynchronous, active-low.
- Reset values:
  - out_valid = 0, all control bits = 0, alu_op = 0.
  - do_extend = 1, is_src1_valid = 1, is_src2_valid = 1.
  - muldiv counter = 0, illegal_op = 0.
- Decode table (unlisted bits keep the reset defaults):
  - opcode 000000: reg_dst = 1, reg_write = 1.
    - func 000000/000010/000011 (shifts): alu_src = 01, is_src1_valid = 0.
    - func 001000 (jr): jr = 1, is_src2_valid = 0.
    - func 011000/011001/011010/011011 (MULT/MULTU/DIV/DIVU): reg_write = 0, alu_op = 1001, is_MD.
    - func 010000/010010 (MFHI/MFLO): alu_op = 1010, is_MF.
  - ADDi 001000: alu_op 0001. ADDiu 001001: alu_op 0010. ANDi 001100: alu_op 0011. XORi 001110: alu_op 0100. ORi 001101: alu_op 0101. SLTi 001010: alu_op 0110. Lui 001111: alu_op 0111.
    - All of these: alu_src = 10, reg_write = 1, is_imm = 1, is_src2_valid = 0.
    - do_extend = 0 for ADDiu, ANDi, XORi, ORi.
  - BEQ/BNE/BLEZ/BGTZ (0001xx): branch = opcode[2:0], alu_op = 1000, is_imm = 1.
    - is_src2_valid = 0 for BLEZ/BGTZ.
  - BGEZ 000001: branch = 001, is_imm = 1, is_src2_valid = 0.
  - j 000010: jump = 01, both src_valid = 0.
  - jal 000011: jump = 10, reg_write = 1, both src_valid = 0.
  - LW 100011 and LB 100000: alu_src = 10, alu_op = 0001, reg_write = 1, mem_read = 1, mem_to_reg = 1, is_imm = 1.
    - LW: is_src2_valid = 0. LB: is_LB_SB = 1.
  - SW 101011 and SB 101000: alu_src = 10, alu_op = 0001, mem_write = 1, is_imm = 1.
    - SB: is_LB_SB = 1.
- Output register load rule: load_en = !out_valid || out_ready.
- Stall condition: stall_md = (is_MD || is_MF) && muldiv_busy.
- in_ready = load_en && !has_hazard && !stall_md && !flush. Combinational; in_valid is not required.
- Cycle actions, in priority order:
  1. flush: out_valid <= 0, nothing consumed.
  2. load_en && in_valid && (has_hazard || stall_md): bubble. out_valid <= 1 with reg_write/mem_write/mem_read/branch/jump/jr = 0 and alu_op = 0. Instruction not consumed.
  3. load_en && in_valid: bundle registered, out_valid <= 1. Latency from accept to out_valid is 1 cycle.
  4. load_en && !in_valid: out_valid <= 0.
  5. Otherwise hold the bundle stable.
- MULT/DIV counter:
  - Loads MULDIV_LAT on acceptance of an is_MD instruction.
  - Decrements each cycle while nonzero, independent of out_ready.
  - muldiv_busy = (counter != 0).
  - The counter is not cleared by flush; the datapath unit runs to completion.
- Boundaries:
  - MULDIV_LAT = 1: a dependent MF accepted 1 cycle after MD at the earliest.
  - MD accepted while the counter reaches 0 in the same cycle: the counter reloads.
  - rst_b low mid-operation: immediate return to the reset values.

Optional Feature:
- Macro: CTRL_ILLEGAL_OP_EN.
- Defined: an accepted opcode not in the table, or an opcode-000000 func outside {shifts, jr, MD, MF, 100000–101011 ALU group}, registers a bubble and sets illegal_op sticky. illegal_op clears only on reset.
- Undefined: an unknown opcode registers the default bundle with out_valid = 1; illegal_op is tied to 0.

Test Plan:
- Reset → out_valid = 0, do_extend = 1, in_ready = 1.
- ADDi (001000) with out_ready = 1 → next cycle out_valid = 1, alu_op = 0001, alu_src = 10, reg_write = 1, is_imm = 1.
- LW, then hold out_ready = 0 for 3 cycles → bundle stable, in_ready = 0, cache_en = 1.
- DIV (func 011010), MULDIV_LAT = 4, followed by MFLO → MFLO accepted exactly 4 cycles after DIV. Bubbles in between; muldiv_busy high for 4 cycles.
- has_hazard with SW presented → bubble with mem_write = 0 and SW not consumed. SW accepted the cycle has_hazard drops.
- flush while out_valid = 1 and out_ready = 0 → out_valid = 0 next cycle. With CTRL_ILLEGAL_OP_EN, opcode 111111 → illegal_op = 1 and stays set.

Source files
------------

// File: rtl/control_issue_unit.sv
// control_issue_unit: registered opcode/func decode with valid/ready output, hazard bubbles, flush and MULT/DIV busy tracking; CTRL_ILLEGAL_OP_EN adds sticky illegal-op detection
module control_issue_unit #(
  parameter int OPCODE_LENGTH = 6,
  parameter int FUNCT_LENGTH  = 6,
  parameter int ALU_OP_WIDTH  = 4,
  parameter int MULDIV_LAT    = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] opcode,
  input  logic [FUNCT_LENGTH-1:0]  func,
  input  logic                     has_hazard,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     reg_write,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     jr,
  output logic                     do_extend,
  output logic                     is_LB_SB,
  output logic                     is_imm,
  output logic                     is_src1_valid,
  output logic                     is_src2_valid,
  output logic [1:0]               alu_src,
  output logic [2:0]               branch,
  output logic [1:0]               jump,
  output logic [ALU_OP_WIDTH-1:0]  alu_op,
  output logic                     cache_en,
  output logic                     muldiv_busy,
  output logic                     illegal_op
);
  localparam int CW = $clog2(MULDIV_LAT + 1);
  typedef struct packed {
    logic                    reg_dst;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    jr;
    logic                    do_extend;
    logic                    is_lb_sb;
    logic                    is_imm;
    logic                    is_src1_valid;
    logic                    is_src2_valid;
    logic [1:0]              alu_src;
    logic [2:0]              branch;
    logic [1:0]              jump;
    logic [ALU_OP_WIDTH-1:0] alu_op;
  } bundle_t;
  localparam bundle_t DEF = '{do_extend: 1'b1, is_src1_valid: 1'b1, is_src2_valid: 1'b1, default: '0};
  bundle_t        dec, q;
  logic           is_md, is_mf, load_en, stall_md, ill;
  logic [CW-1:0]  cnt;
  // decode table; the default bundle doubles as the bubble
  always_comb begin
    dec = DEF;
    is_md = 1'b0;
    is_mf = 1'b0;
    case (opcode)
      6'b000000: begin
        dec.reg_dst = 1'b1;
        dec.reg_write = 1'b1;
        case (func)
          6'b000000, 6'b000010, 6'b000011: begin
            dec.alu_src = 2'b01;
            dec.is_src1_valid = 1'b0;
          end
          6'b001000: begin
            dec.jr = 1'b1;
            dec.is_src2_valid = 1'b0;
          end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            dec.reg_write = 1'b0;
            dec.alu_op = ALU_OP_WIDTH'(4'b1001);
            is_md = 1'b1;
          end
          6'b010000, 6'b010010: begin
            dec.alu_op = ALU_OP_WIDTH'(4'b1010);
            is_mf = 1'b1;
          end
          default: ;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.alu_src = 2'b10;
        dec.reg_write = 1'b1;
        dec.is_imm = 1'b1;
        dec.is_src2_valid = 1'b0;
        dec.do_extend = !(opcode inside {6'b001001, 6'b001100, 6'b001101, 6'b001110});
        dec.alu_op = ALU_OP_WIDTH'(opcode == 6'b001000 ? 4'b0001 :
                                   opcode == 6'b001001 ? 4'b0010 :
                                   opcode == 6'b001100 ? 4'b0011 :
                                   opcode == 6'b001110 ? 4'b0100 :
                                   opcode == 6'b001101 ? 4'b0101 :
                                   opcode == 6'b001010 ? 4'b0110 : 4'b0111);
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        dec.branch = opcode[2:0];
        dec.alu_op = ALU_OP_WIDTH'(4'b1000);
        dec.is_imm = 1'b1;
        dec.is_src2_valid = !opcode[1];
      end
      6'b000001: begin
        dec.branch = 3'b001;
        dec.is_imm = 1'b1;
        dec.is_src2_valid = 1'b0;
      end
      6'b000010, 6'b000011: begin
        dec.jump = opcode[0] ? 2'b10 : 2'b01;
        dec.reg_write = opcode[0];
        dec.is_src1_valid = 1'b0;
        dec.is_src2_valid = 1'b0;
      end
      6'b100011, 6'b100000: begin
        dec.alu_src = 2'b10;
        dec.alu_op = ALU_OP_WIDTH'(4'b0001);
        dec.reg_write = 1'b1;
        dec.mem_read = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.is_imm = 1'b1;
        dec.is_src2_valid = !opcode[0];
        dec.is_lb_sb = !opcode[0];
      end
      6'b101011, 6'b101000: begin
        dec.alu_src = 2'b10;
        dec.alu_op = ALU_OP_WIDTH'(4'b0001);
        dec.mem_write = 1'b1;
        dec.is_imm = 1'b1;
        dec.is_lb_sb = !opcode[0];
      end
      default: ;
    endcase
  end
  assign muldiv_busy = |cnt;
  assign load_en = !out_valid || out_ready;
  assign stall_md = (is_md || is_mf) && muldiv_busy;
  assign in_ready = load_en && !has_hazard && !stall_md && !flush;
  assign cache_en = q.mem_read | q.mem_write;
  assign {reg_dst, mem_to_reg, reg_write, mem_read, mem_write, jr, do_extend, is_LB_SB, is_imm,
          is_src1_valid, is_src2_valid, alu_src, branch, jump, alu_op} = q;
`ifdef CTRL_ILLEGAL_OP_EN
  logic ill_q;
  assign ill = (opcode == '0) ?
    !(func inside {6'd0, 6'd2, 6'd3, 6'd8, [6'd24:6'd27], 6'd16, 6'd18, [6'd32:6'd43]}) :
    !(opcode inside {[6'd1:6'd10], [6'd12:6'd15], 6'd32, 6'd35, 6'd40, 6'd43});
  assign illegal_op = ill_q;
  // sticky flag set by any consumed illegal instruction
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) ill_q <= 1'b0;
    else if (in_valid && in_ready && ill) ill_q <= 1'b1;
`else
  assign ill = 1'b0;
  assign illegal_op = 1'b0;
`endif
  // MULT/DIV countdown runs free of the output handshake and survives flush
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) cnt <= '0;
    else cnt <= (in_valid && in_ready && is_md) ? CW'(MULDIV_LAT) : cnt - CW'(muldiv_busy);
  // output register: flush kills, stalls register a bubble, otherwise load or drain
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      out_valid <= 1'b0;
      q <= DEF;
    end else if (flush) out_valid <= 1'b0;
    else if (load_en) begin
      out_valid <= in_valid;
      if (in_valid) q <= (has_hazard || stall_md || ill) ? DEF : dec;
    end
endmodule

// File: tb/tb_control_issue_unit.sv
// tb_control_issue_unit: directed and random stimulus checked every cycle against a table-driven issue model
module tb_control_issue_unit;
  localparam int LAT = 4;
  localparam logic [21:0] MASK = 22'h0F01FF;
`ifdef CTRL_ILLEGAL_OP_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif
  logic clk = 1'b0, rst_b = 1'b0, in_valid = 1'b0, has_hazard = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic in_ready, out_valid, reg_dst, mem_to_reg, reg_write, mem_read, mem_write, jr, do_extend;
  logic is_LB_SB, is_imm, is_src1_valid, is_src2_valid, cache_en, muldiv_busy, illegal_op;
  logic [1:0] alu_src, jump;
  logic [2:0] branch;
  logic [3:0] alu_op;
  logic [21:0] dut_b;
  int n_chk = 0, n_fail = 0;
  bit run = 1'b0;
  bit mv = 1'b0, mbub = 1'b0, ill = 1'b0;
  logic [21:0] mb = '0;
  int md_left = 0;

  control_issue_unit #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .func(func),
    .has_hazard(has_hazard), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .jr(jr), .do_extend(do_extend), .is_LB_SB(is_LB_SB), .is_imm(is_imm),
    .is_src1_valid(is_src1_valid), .is_src2_valid(is_src2_valid), .alu_src(alu_src), .branch(branch),
    .jump(jump), .alu_op(alu_op), .cache_en(cache_en), .muldiv_busy(muldiv_busy), .illegal_op(illegal_op)
  );

  assign dut_b = {reg_dst, mem_to_reg, reg_write, mem_read, mem_write, jr, do_extend, is_LB_SB, is_imm,
                  is_src1_valid, is_src2_valid, alu_src, branch, jump, alu_op};

  always #5 clk = ~clk;

  function automatic logic [21:0] dec(input logic [5:0] op, input logic [5:0] fn);
    logic rd = 0, mtr = 0, rw = 0, mr = 0, mw = 0, j = 0, ext = 1, lbsb = 0, imm = 0, s1 = 1, s2 = 1;
    logic [1:0] asrc = 0, jmp = 0;
    logic [2:0] br = 0;
    logic [3:0] aop = 0;
    if (op == 6'd0) begin
      rd = 1; rw = 1;
      if (fn inside {6'd0, 6'd2, 6'd3}) begin asrc = 2'd1; s1 = 0; end
      else if (fn == 6'd8) begin j = 1; s2 = 0; end
      else if (fn inside {[6'd24:6'd27]}) begin rw = 0; aop = 4'd9; end
      else if (fn inside {6'd16, 6'd18}) aop = 4'd10;
    end else if (op inside {[6'd8:6'd10], [6'd12:6'd15]}) begin
      asrc = 2'd2; rw = 1; imm = 1; s2 = 0;
      ext = !(op inside {6'd9, 6'd12, 6'd13, 6'd14});
      aop = op == 6'd8 ? 4'd1 : op == 6'd9 ? 4'd2 : op == 6'd12 ? 4'd3 : op == 6'd14 ? 4'd4 :
            op == 6'd13 ? 4'd5 : op == 6'd10 ? 4'd6 : 4'd7;
    end else if (op inside {[6'd4:6'd7]}) begin
      br = op[2:0]; aop = 4'd8; imm = 1; s2 = !(op inside {6'd6, 6'd7});
    end else if (op == 6'd1) begin br = 3'd1; imm = 1; s2 = 0; end
    else if (op == 6'd2) begin jmp = 2'd1; s1 = 0; s2 = 0; end
    else if (op == 6'd3) begin jmp = 2'd2; rw = 1; s1 = 0; s2 = 0; end
    else if (op inside {6'd32, 6'd35}) begin
      asrc = 2'd2; aop = 4'd1; rw = 1; mr = 1; mtr = 1; imm = 1; s2 = (op != 6'd35); lbsb = (op == 6'd32);
    end else if (op inside {6'd40, 6'd43}) begin
      asrc = 2'd2; aop = 4'd1; mw = 1; imm = 1; lbsb = (op == 6'd40);
    end
    return {rd, mtr, rw, mr, mw, j, ext, lbsb, imm, s1, s2, asrc, br, jmp, aop};
  endfunction

  function automatic bit known(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'd0 ? fn inside {6'd0, 6'd2, 6'd3, 6'd8, [6'd24:6'd27], 6'd16, 6'd18, [6'd32:6'd43]}
                      : op inside {[6'd1:6'd10], [6'd12:6'd15], 6'd32, 6'd35, 6'd40, 6'd43};
  endfunction

  function automatic bit is_md(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'd0 && fn inside {[6'd24:6'd27]};
  endfunction

  function automatic bit blocked();
    return (is_md(opcode, func) || (opcode == 6'd0 && func inside {6'd16, 6'd18})) && md_left > 0;
  endfunction

  function automatic bit exp_rdy();
    return (!mv || out_ready) && !has_hazard && !blocked() && !flush;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic reset_model();
    mv = 0; mbub = 0; ill = 0; md_left = 0;
  endtask

  task automatic step();
    bit ld, st, acc, il;
    ld = !mv || out_ready;
    st = blocked();
    acc = in_valid && exp_rdy();
    il = ILL && !known(opcode, func);
    md_left = (acc && is_md(opcode, func)) ? LAT : (md_left > 0 ? md_left - 1 : 0);
    if (acc && il) ill = 1;
    if (flush) mv = 0;
    else if (ld && in_valid) begin
      mv = 1;
      mbub = has_hazard || st || il;
      if (!mbub) mb = dec(opcode, func);
    end else if (ld) mv = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_b) step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic hz, input logic fl, input logic rdy);
    in_valid = v; opcode = op; func = fn; has_hazard = hz; flush = fl; out_ready = rdy;
  endtask

  always @(negedge clk)
    if (run && rst_b) begin
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy()));
      chk("muldiv_busy", 32'(muldiv_busy), 32'(md_left > 0));
      chk("illegal_op", 32'(illegal_op), 32'(ill));
      if (mv) begin
        if (mbub) chk("bubble_bits", 32'(dut_b & MASK), 32'd0);
        else chk("bundle", 32'(dut_b), 32'(mb));
        chk("cache_en", 32'(cache_en), 32'(!mbub && (mb[18] | mb[17])));
      end
    end

  initial begin
    int k;
    logic [5:0] ops[19] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                            6'd12, 6'd13, 6'd14, 6'd15, 6'd32, 6'd35, 6'd40, 6'd43};
    logic [5:0] fns[14] = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd24, 6'd25, 6'd26, 6'd27, 6'd16, 6'd18,
                            6'd32, 6'd33, 6'd36, 6'd42};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_do_extend", 32'(do_extend), 32'd1);
    chk("rst_src1_valid", 32'(is_src1_valid), 32'd1);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst_b = 1'b1;
    reset_model();
    run = 1'b1;
    drive(1, 6'd8, 6'd0, 0, 0, 1);
    cyc();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_alu_op", 32'(alu_op), 32'd1);
    chk("addi_alu_src", 32'(alu_src), 32'd2);
    chk("addi_reg_write", 32'(reg_write), 32'd1);
    chk("addi_is_imm", 32'(is_imm), 32'd1);
    drive(1, 6'd35, 6'd0, 0, 0, 1);
    cyc();
    drive(1, 6'd8, 6'd0, 0, 0, 0);
    repeat (3) begin
      cyc();
      chk("lw_hold_valid", 32'(out_valid), 32'd1);
      chk("lw_hold_mem_read", 32'(mem_read), 32'd1);
      chk("lw_hold_cache_en", 32'(cache_en), 32'd1);
      chk("lw_hold_in_ready", 32'(in_ready), 32'd0);
    end
    drive(1, 6'd0, 6'd26, 0, 0, 1);
    cyc();
    chk("div_busy", 32'(muldiv_busy), 32'd1);
    drive(1, 6'd0, 6'd18, 0, 0, 1);
    #1 k = 0;
    while (!in_ready && k < 20) begin
      cyc();
      #1 k++;
    end
    chk("mflo_stall_cycles", 32'(k), 32'd4);
    cyc();
    chk("mflo_alu_op", 32'(alu_op), 32'd10);
    chk("mflo_reg_write", 32'(reg_write), 32'd1);
    drive(1, 6'd43, 6'd0, 1, 0, 1);
    cyc();
    chk("haz_valid", 32'(out_valid), 32'd1);
    chk("haz_mem_write", 32'(mem_write), 32'd0);
    chk("haz_in_ready", 32'(in_ready), 32'd0);
    drive(1, 6'd43, 6'd0, 0, 0, 1);
    #1 chk("haz_drop_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("sw_mem_write", 32'(mem_write), 32'd1);
    drive(1, 6'd35, 6'd0, 0, 0, 1);
    cyc();
    drive(1, 6'd35, 6'd0, 0, 1, 0);
    cyc();
    chk("flush_valid", 32'(out_valid), 32'd0);
    drive(1, 6'd63, 6'd0, 0, 0, 1);
    cyc();
    chk("unk_valid", 32'(out_valid), 32'd1);
    chk("unk_alu_op", 32'(alu_op), 32'd0);
    chk("unk_illegal", 32'(illegal_op), 32'(ILL));
    drive(0, 6'd0, 6'd0, 0, 0, 1);
    cyc();
    chk("illegal_sticky", 32'(illegal_op), 32'(ILL));
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0 ? 6'($urandom) : ($urandom_range(0, 9) < 3 ? 6'd0 : ops[$urandom_range(0, 18)]),
            $urandom_range(0, 9) == 0 ? 6'($urandom) : fns[$urandom_range(0, 13)],
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, $urandom_range(0, 9) < 7);
      cyc();
    end
    drive(1, 6'd0, 6'd24, 0, 0, 1);
    k = 0;
    while (!in_ready && k < 20) begin
      cyc();
      k++;
    end
    cyc();
    chk("mult_busy_pre_reset", 32'(muldiv_busy), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(muldiv_busy), 32'd0);
    chk("midrst_alu_op", 32'(alu_op), 32'd0);
    chk("midrst_do_extend", 32'(do_extend), 32'd1);
    reset_model();
    @(posedge clk);
    #2 rst_b = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0 ? 6'd0 : ops[$urandom_range(0, 18)],
            fns[$urandom_range(0, 13)], $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 6);
      cyc();
    end
    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
